// File: rtl/pocket_pkg.sv
// Shared types and widths for the pocket detector.
package pocket_pkg;

  localparam int COUNT_W    = 11;
  localparam int HOLE_IDX_W = 3;
  localparam logic [COUNT_W-1:0] COUNT_MAX = 11'd2047;

  typedef enum logic [1:0] {
    SCAN    = 2'd0,
    CONFIRM = 2'd1,
    LOCKOUT = 2'd2
  } state_t;

endpackage

// File: rtl/overlap_counter.sv
// Per-hole ball/hole overlap counter: saturating pixel count for the current
// frame, latched into frameCount_o on startOfFrame. The startOfFrame pixel
// itself belongs to the new frame.
module overlap_counter
  import pocket_pkg::*;
(
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame_i,
  input  logic               hit_i,
  output logic [COUNT_W-1:0] frameCount_o,
  output logic               nonzero_o
);

  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic [COUNT_W-1:0] frame_q, frame_d;

  // Next-state: latch and reload on frame start, otherwise saturating count.
  always_comb begin
    cnt_d   = cnt_q;
    frame_d = frame_q;
    if (startOfFrame_i) begin
      frame_d = cnt_q;
      cnt_d   = hit_i ? COUNT_W'(1) : '0;
    end else if (hit_i && (cnt_q != COUNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      cnt_q   <= '0;
      frame_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
    end
  end

  assign frameCount_o = frame_q;
  assign nonzero_o    = |frame_q;

endmodule

// File: rtl/pocket_detector.sv
// Pocket detector: counts ball/hole overlap per frame for every hole, picks the
// lowest-index hole over threshold one cycle after startOfFrame, and confirms
// it over FRAMES_CONFIRM consecutive frames before a one-cycle pocketed pulse.
// A lockout state then waits for a fully clean frame to avoid double reports.
// Optional debug ports are enabled by defining POCKET_DEBUG_EN.
module pocket_detector
  import pocket_pkg::*;
#(
  parameter int NUM_HOLES         = 6,
  parameter int OVERLAP_THRESHOLD = 200,
  parameter int FRAMES_CONFIRM    = 2
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  startOfFrame,
  input  logic                  drawingRequestBall,
  input  logic [NUM_HOLES-1:0]  drawingRequestHoles,
  input  logic                  pocketEnable,
  output logic                  pocketed,
  output logic [HOLE_IDX_W-1:0] pocketedHole,
  output logic                  busy
`ifdef POCKET_DEBUG_EN
  ,
  output logic [COUNT_W-1:0]    debugOverlap,
  output logic [1:0]            debugState
`endif
);

  localparam logic [COUNT_W-1:0] THR    = COUNT_W'(OVERLAP_THRESHOLD);
  localparam logic [3:0]         FC_TGT = 4'(FRAMES_CONFIRM);

  logic [COUNT_W-1:0]    frame_cnt [NUM_HOLES];
  logic [NUM_HOLES-1:0]  nonzero;
  logic                  eval_q;
  logic                  qualify;
  logic [HOLE_IDX_W-1:0] best;

  state_t                state_q, state_d;
  logic [HOLE_IDX_W-1:0] cand_q, cand_d;
  logic [3:0]            conf_q, conf_d;
  logic                  pocketed_q, pocketed_d;
  logic [HOLE_IDX_W-1:0] hole_q, hole_d;

  for (genvar g = 0; g < NUM_HOLES; g++) begin : g_hole
    overlap_counter u_cnt (
      .clk            (clk),
      .resetN         (resetN),
      .startOfFrame_i (startOfFrame),
      .hit_i          (drawingRequestBall & drawingRequestHoles[g]),
      .frameCount_o   (frame_cnt[g]),
      .nonzero_o      (nonzero[g])
    );
  end

  // Evaluation strobe: frame counts are valid the cycle after startOfFrame.
  always_ff @(posedge clk) begin
    if (!resetN) eval_q <= 1'b0;
    else         eval_q <= startOfFrame;
  end

  // Priority select: scan high to low so the lowest qualifying index wins.
  always_comb begin
    qualify = 1'b0;
    best    = '0;
    for (int i = NUM_HOLES - 1; i >= 0; i--) begin
      if (frame_cnt[i] >= THR) begin
        qualify = 1'b1;
        best    = HOLE_IDX_W'(i);
      end
    end
  end

  // FSM next-state, advanced once per frame on the evaluation strobe.
  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    conf_d     = conf_q;
    hole_d     = hole_q;
    pocketed_d = 1'b0;
    if (eval_q) begin
      case (state_q)
        SCAN: begin
          if (qualify && pocketEnable) begin
            cand_d = best;
            if (FRAMES_CONFIRM == 1) begin
              pocketed_d = 1'b1;
              hole_d     = best;
              conf_d     = '0;
              state_d    = LOCKOUT;
            end else begin
              conf_d  = 4'd1;
              state_d = CONFIRM;
            end
          end
        end
        CONFIRM: begin
          if (qualify && (best == cand_q) && pocketEnable) begin
            if ((conf_q + 4'd1) == FC_TGT) begin
              pocketed_d = 1'b1;
              hole_d     = cand_q;
              conf_d     = '0;
              state_d    = LOCKOUT;
            end else begin
              conf_d = conf_q + 4'd1;
            end
          end else begin
            conf_d  = '0;
            state_d = SCAN;
          end
        end
        LOCKOUT: begin
          if (~|nonzero) state_d = SCAN;
        end
        default: state_d = SCAN;
      endcase
    end
  end

  // FSM and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q    <= SCAN;
      cand_q     <= '0;
      conf_q     <= '0;
      hole_q     <= '0;
      pocketed_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      conf_q     <= conf_d;
      hole_q     <= hole_d;
      pocketed_q <= pocketed_d;
    end
  end

  assign pocketed     = pocketed_q;
  assign pocketedHole = hole_q;
  assign busy         = (state_q != SCAN);

`ifdef POCKET_DEBUG_EN
  assign debugOverlap = (state_q == SCAN) ? '0 : frame_cnt[cand_q];
  assign debugState   = state_q;
`endif

endmodule

// File: tb/tb_pocket_detector.sv
// Scoreboard bench for pocket_detector: frames are driven as directed vectors,
// expected pulses (cycle, hole) are queued at the closing startOfFrame and a
// monitor matches every pocketed pulse against the queue.
module tb_pocket_detector;

  localparam int NH = 6;
  localparam int L  = 400;

  logic          clk = 1'b0;
  logic          resetN;
  logic          startOfFrame;
  logic          drawingRequestBall;
  logic [NH-1:0] drawingRequestHoles;
  logic          pocketEnable;
  logic          pocketed;
  logic [2:0]    pocketedHole;
  logic          busy;
`ifdef POCKET_DEBUG_EN
  logic [10:0]   debugOverlap;
  logic [1:0]    debugState;
`endif

  pocket_detector #(
    .NUM_HOLES         (NH),
    .OVERLAP_THRESHOLD (200),
    .FRAMES_CONFIRM    (2)
  ) dut (
    .clk                 (clk),
    .resetN              (resetN),
    .startOfFrame        (startOfFrame),
    .drawingRequestBall  (drawingRequestBall),
    .drawingRequestHoles (drawingRequestHoles),
    .pocketEnable        (pocketEnable),
    .pocketed            (pocketed),
    .pocketedHole        (pocketedHole),
    .busy                (busy)
`ifdef POCKET_DEBUG_EN
    ,
    .debugOverlap        (debugOverlap),
    .debugState          (debugState)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int c;
    int h;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (pocketed) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pulse: pulse at cycle %0d hole %0d, required none",
                 cyc, pocketedHole);
      end else begin
        e = exp_q.pop_front();
        check("pulse_cycle", cyc, e.c);
        check("pulse_hole", int'(pocketedHole), e.h);
      end
    end
  end

  // One frame of L pixels: SOF on pixel 0, overlap on pixels 1..n for holes in
  // mask. exp_hole >= 0 queues a pulse 2 cycles after this frame's SOF.
  task automatic frame(input logic [NH-1:0] mask, input int n, input bit sof_hit,
                       input int exp_hole);
    exp_t e;
    for (int c = 0; c < L; c++) begin
      @(posedge clk);
      #1;
      startOfFrame = (c == 0);
      if (c == 0) begin
        if (exp_hole >= 0) begin
          e.c = cyc + 2;
          e.h = exp_hole;
          exp_q.push_back(e);
        end
        drawingRequestBall  = sof_hit;
        drawingRequestHoles = sof_hit ? mask : '0;
      end else begin
        drawingRequestBall  = (c <= n);
        drawingRequestHoles = (c <= n) ? mask : '0;
      end
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    resetN              = 1'b0;
    startOfFrame        = 1'b0;
    drawingRequestBall  = 1'b0;
    drawingRequestHoles = '0;
    @(posedge clk);
    #1;
    check("reset_busy", int'(busy), 0);
    check("reset_pocketed", int'(pocketed), 0);
    resetN = 1'b1;
  endtask

  initial begin
    exp_t e;
    resetN              = 1'b0;
    startOfFrame        = 1'b0;
    drawingRequestBall  = 1'b0;
    drawingRequestHoles = '0;
    pocketEnable        = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("init_pocketed", int'(pocketed), 0);
    check("init_hole", int'(pocketedHole), 0);
    check("init_busy", int'(busy), 0);
    resetN = 1'b1;

    // 1: three frames on hole 2, pulse after the third SOF
    frame(6'b000100, 300, 1'b0, -1);
    frame(6'b000100, 300, 1'b0, -1);
    check("t1_confirm_busy", int'(busy), 1);
    frame(6'b000100, 300, 1'b0, 2);
    check("t1_lockout_busy", int'(busy), 1);
    check("t1_hole", int'(pocketedHole), 2);
    frame(6'b000000, 0, 1'b0, -1);
    check("t1_still_lockout", int'(busy), 1);
    frame(6'b000000, 0, 1'b0, -1);
    check("t1_back_scan", int'(busy), 0);

    // 2: 199 stays in SCAN, 250 enters CONFIRM, zero frame drops back
    frame(6'b000001, 199, 1'b0, -1);
    frame(6'b000001, 250, 1'b0, -1);
    check("t2_199_scan", int'(busy), 0);
    frame(6'b000000, 0, 1'b0, -1);
    check("t2_250_confirm", int'(busy), 1);
    frame(6'b000000, 0, 1'b0, -1);
    check("t2_zero_scan", int'(busy), 0);

    // 3: holes 1 and 4 tie, lowest index reported
    frame(6'b010010, 300, 1'b0, -1);
    frame(6'b010010, 300, 1'b0, -1);
    frame(6'b000000, 0, 1'b0, 1);
    frame(6'b000000, 0, 1'b0, -1);
    check("t3_hole", int'(pocketedHole), 1);
    check("t3_scan", int'(busy), 0);

    // 4: pocketEnable low at the confirming evaluation
    frame(6'b001000, 300, 1'b0, -1);
    frame(6'b001000, 300, 1'b0, -1);
    check("t4_confirm", int'(busy), 1);
    pocketEnable = 1'b0;
    frame(6'b000000, 0, 1'b0, -1);
    check("t4_scan", int'(busy), 0);
    pocketEnable = 1'b1;
    frame(6'b000000, 0, 1'b0, -1);

    // 5: lingering on hole 5 after a report, then clean frame and re-report
    frame(6'b100000, 300, 1'b0, -1);
    frame(6'b100000, 300, 1'b0, -1);
    frame(6'b100000, 300, 1'b0, 5);
    frame(6'b100000, 300, 1'b0, -1);
    frame(6'b100000, 300, 1'b0, -1);
    frame(6'b100000, 300, 1'b0, -1);
    check("t5_linger_lockout", int'(busy), 1);
    frame(6'b000000, 0, 1'b0, -1);
    frame(6'b100000, 300, 1'b0, -1);
    check("t5_rescan", int'(busy), 0);
    frame(6'b100000, 300, 1'b0, -1);
    frame(6'b000000, 0, 1'b0, 5);
    frame(6'b000000, 0, 1'b0, -1);
    check("t5_hole", int'(pocketedHole), 5);
    check("t5_scan", int'(busy), 0);

    // 6: SOF pixel counts into the new frame (1 + 199 = threshold), then
    //    reset mid-CONFIRM suppresses the pending pulse
    frame(6'b000001, 199, 1'b1, -1);
    frame(6'b000001, 300, 1'b0, -1);
    check("t6_sof_pixel_confirm", int'(busy), 1);
    pulse_reset();
    frame(6'b000000, 0, 1'b0, -1);
    check("t6_after_reset_scan", int'(busy), 0);
    check("t6_after_reset_hole", int'(pocketedHole), 0);

    repeat (10) @(posedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      n_err++;
      $display("FAIL missing_pulse: got none, required pulse at cycle %0d hole %0d", e.c, e.h);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pocket_detector.md
Name: pocket_detector

Overview:
- Consumes the per-pixel drawing requests produced by the hole bitmap drawers and the ball drawer.
- Decides when the ball has dropped into a pocket.
- Counts ball/hole overlap pixels per frame for each hole and confirms a pocket over consecutive frames.
- Emits a one-cycle pocket event with the hole index to the game-control FSM.

Parameters:
- NUM_HOLES, 6, number of hole drawing-request inputs (max 8).
- OVERLAP_THRESHOLD, 200, minimum overlap pixels in one frame for that frame to count as "in pocket".
- FRAMES_CONFIRM, 2, consecutive qualifying frames required before reporting (1..15).

Ports:
- clk  in  1  system pixel clock
- resetN  in  1  synchronous active-low reset
- startOfFrame  in  1  one-cycle pulse at first pixel of each frame
- drawingRequestBall  in  1  ball pixel opaque this cycle (registered, same alignment as hole requests)
- drawingRequestHoles  in  NUM_HOLES  bit i = hole i pixel opaque this cycle
- pocketEnable  in  1  game FSM allows pocket reporting (ball in motion)
- pocketed  out  1  one-cycle pulse: pocket confirmed
- pocketedHole  out  3  index of confirmed hole; held until next report
- busy  out  1  high while in CONFIRM or LOCKOUT

Behaviour:
- Clock and reset: one clock, clk. resetN is synchronous and active-low. Reset clears all counters, state to SCAN, pocketed=0, pocketedHole=0, busy=0.
- Overlap counting:
  - Per hole i, an 11-bit counter increments each cycle where drawingRequestBall && drawingRequestHoles[i].
  - The counter saturates at 2047.
- Frame boundary:
  - On startOfFrame, each counter's value is latched into frameCount[i].
  - In the same cycle the counter reloads to 1 if an overlap exists that cycle, else 0. That pixel belongs to the new frame.
- Evaluation, one cycle after startOfFrame:
  - best = lowest index i with frameCount[i] >= OVERLAP_THRESHOLD.
  - qualify = such an i exists. Ties go to the lowest index.
- States:
  - SCAN:
    - If qualify && pocketEnable: candidate=best, confirmCnt=1, go to CONFIRM.
    - If FRAMES_CONFIRM==1, report immediately instead (go to LOCKOUT with a pulse).
  - CONFIRM, evaluated per frame:
    - qualify && best==candidate && pocketEnable: confirmCnt++.
    - When confirmCnt reaches FRAMES_CONFIRM: pocketed=1 for exactly one cycle, pocketedHole=candidate, go to LOCKOUT.
    - Otherwise (no qualify, different hole, or pocketEnable low): return to SCAN, confirmCnt=0.
  - LOCKOUT:
    - Wait for one full frame with every frameCount[i]==0.
    - Then go to SCAN. Prevents double reporting while the ball sprite lingers.
- pocketEnable low in SCAN: counting continues, no transition.
- pocketed never asserts on two consecutive cycles. Latency: the pulse comes 2 cycles after the startOfFrame that closes the final qualifying frame.
- Reset mid-CONFIRM or mid-LOCKOUT: immediate return to SCAN, no pulse.

Optional Feature:
- Macro POCKET_DEBUG_EN.
- When defined:
  - Adds output debugOverlap (11 bits), the latched frameCount of the current candidate (0 in SCAN).
  - Adds output debugState (2 bits), the encoded FSM state, for the on-screen debug overlay.
- When undefined: these ports are absent and functional behaviour is identical.

Decomposition:
- Package pocket_pkg:
  - state enum {SCAN, CONFIRM, LOCKOUT}
  - COUNT_W=11, HOLE_IDX_W=3, COUNT_MAX=2047
- Sub-module overlap_counter:
  - One instance per hole via generate.
  - Contents: saturating per-frame counter plus the latch on startOfFrame.
  - Outputs frameCount and nonzero.
- The FSM and the priority select live in the top.

Test Plan:
1. Reset, then 3 frames with 300 overlap pixels on hole 2 each, pocketEnable=1, FRAMES_CONFIRM=2:
   - pocketed pulses once, 2 cycles after the 3rd startOfFrame (the one closing the 2nd qualifying frame).
   - pocketedHole=2.
2. Frame with 199 overlap pixels on hole 0, then 250 → reaches CONFIRM only; a following frame with 0 → back to SCAN, no pulse.
3. Holes 1 and 4 both at 300 for 2 frames → pocketedHole=1.
4. Qualifying on hole 3, but pocketEnable drops during the confirm frame → no pulse, state SCAN.
5. After a report, ball stays over hole 5 for 4 frames → no further pulse. Then one zero-overlap frame, then 2 qualifying frames → second pulse.
6. Overlap pixel coincident with startOfFrame → new-frame count starts at 1. Assert resetN=0 mid-CONFIRM → busy=0 and no pulse next cycle.
